// File: rtl/multicycle_adder.sv
// ---------------------------------------------------------------------------
// multicycle_adder
//
// Ripple-style adder/subtractor that processes CHUNK bits per clock. A WIDTH-
// bit operation takes NCHUNK = WIDTH/CHUNK cycles in RUN, followed by a
// one-cycle DONE state that pulses `done`. Results (S, carry_out, overflow)
// update only when an operation completes and hold otherwise.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   start      in   request a new operation (accepted in IDLE or DONE)
//   sub        in   0: A + B + carry_in, 1: A - B
//   A, B       in   WIDTH-bit operands, captured on an accepted start
//   carry_in   in   carry into bit 0 (add mode only)
//   busy       out  high while chunks are being processed
//   done       out  one-cycle pulse, result valid
//   S          out  WIDTH-bit result
//   carry_out  out  carry out of the MSB (sub: 1 = no borrow)
//   overflow   out  two's-complement signed overflow
// ---------------------------------------------------------------------------
module multicycle_adder #(
   parameter int WIDTH = 32,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             carry_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] S,
   output logic             carry_out,
   output logic             overflow
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [KW-1:0] K_LAST = KW'(NCHUNK - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // One chunk of the ripple: CHUNK-bit sum plus carry-out in the top bit.
   function automatic logic [CHUNK:0] chunk_add(input logic [CHUNK-1:0] a,
                                                input logic [CHUNK-1:0] b,
                                                input logic             c);
      return {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, c};
   endfunction

   state_t           state_q, state_nxt;
   logic [WIDTH-1:0] a_q, b_q, shadow_q, shadow_nxt;
   logic [KW-1:0]    k_q;
   logic             carry_q;
   logic [CHUNK-1:0] a_chunk, b_chunk;
   logic [CHUNK:0]   chunk_sum;
   logic             msb_cin;
   logic             last;
   logic             accept;

   assign accept = start && (state_q != RUN);
   assign last   = (k_q == K_LAST);

   // Select chunk k of each operand and merge its sum into the shadow result.
   always_comb begin
      a_chunk    = '0;
      b_chunk    = '0;
      for (int i = 0; i < NCHUNK; i++) begin
         if (k_q == KW'(i)) begin
            a_chunk = a_q[i*CHUNK +: CHUNK];
            b_chunk = b_q[i*CHUNK +: CHUNK];
         end
      end
      chunk_sum  = chunk_add(a_chunk, b_chunk, carry_q);
      shadow_nxt = shadow_q;
      for (int i = 0; i < NCHUNK; i++) begin
         if (k_q == KW'(i)) begin
            shadow_nxt[i*CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
         end
      end
      // Carry into the top bit recovered from that bit's sum and inputs;
      // only meaningful while the last chunk is being processed.
      msb_cin = chunk_sum[CHUNK-1] ^ a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1];
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_nxt;
      end
   end

   // FSM next-state logic
   always_comb begin
      state_nxt = state_q;
      case (state_q)
         IDLE:    state_nxt = start ? RUN : IDLE;
         RUN:     state_nxt = last ? DONE : RUN;
         DONE:    state_nxt = start ? RUN : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // FSM outputs
   always_comb begin
      busy = (state_q == RUN);
      done = (state_q == DONE);
   end

   // Operand capture, chunk processing and result publication
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q       <= '0;
         b_q       <= '0;
         shadow_q  <= '0;
         carry_q   <= 1'b0;
         k_q       <= '0;
         S         <= '0;
         carry_out <= 1'b0;
         overflow  <= 1'b0;
      end else if (accept) begin
         // Subtraction is A + ~B + 1: invert B once here, seed the carry.
         a_q      <= A;
         b_q      <= sub ? ~B : B;
         carry_q  <= sub ? 1'b1 : carry_in;
         k_q      <= '0;
         shadow_q <= '0;
      end else if (state_q == RUN) begin
         shadow_q <= shadow_nxt;
         carry_q  <= chunk_sum[CHUNK];
         k_q      <= last ? '0 : k_q + KW'(1);
         if (last) begin
            S         <= shadow_nxt;
            carry_out <= chunk_sum[CHUNK];
            overflow  <= msb_cin ^ chunk_sum[CHUNK];
         end
      end
   end

endmodule
